video_timing_meter: RTL

- Measures incoming Amiga video sync timing: clocks per line, lines per frame, clocks per frame and a frame counter.
- Presents one selected statistic as a 24-bit value on `values`. `values` feeds the six-digit hex seven-segment decoder stage directly, so bring-up can read scan timing off the board display.
- Sync inputs may be asynchronous to `clk` and are synchronized internally.

---
 rtl/video_timing_meter.sv | 81 ++++++++
 1 files changed

// File: rtl/video_timing_meter.sv
// video_timing_meter: measures sync timing (clocks/line, lines/frame, clocks/frame, frames)
// and presents one selected statistic as a registered 24-bit value.
module video_timing_meter #(
    parameter bit          HSYNC_ACTIVE_LOW = 1'b1,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter logic [23:0] TIMEOUT          = 24'd4000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [1:0]  sel,
    input  logic        hold,
    output logic [23:0] values,
    output logic        locked
);
    typedef enum logic [1:0] {NO_SIGNAL, FIRST, LOCKED} state_t;
    state_t state, state_next;
    logic [1:0]  hs, vs;
    logic        h_prev, v_prev, h_edge, v_edge, timeout;
    logic [15:0] line_clk, clk_line;
    logic [23:0] frame_clk, clk_frame, frame_cnt, sel_val;
    logic [11:0] line_cnt, lines;
    // XOR with the polarity parameter turns "at asserted level" into a plain high test
    assign h_edge  = (hs[1] ^ HSYNC_ACTIVE_LOW) & ~(h_prev ^ HSYNC_ACTIVE_LOW);
    assign v_edge  = (vs[1] ^ VSYNC_ACTIVE_LOW) & ~(v_prev ^ VSYNC_ACTIVE_LOW);
    assign timeout = frame_clk == TIMEOUT;
    always_comb begin
        state_next = timeout ? NO_SIGNAL : v_edge ? (state == NO_SIGNAL ? FIRST : LOCKED) : state;
        sel_val    = sel == 2'd0 ? {12'd0, lines} : sel == 2'd1 ? {8'd0, clk_line} :
                     sel == 2'd2 ? clk_frame : frame_cnt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hs        <= '0;
            vs        <= '0;
            h_prev    <= 1'b0;
            v_prev    <= 1'b0;
            line_clk  <= '0;
            frame_clk <= '0;
            line_cnt  <= '0;
            clk_line  <= '0;
            clk_frame <= '0;
            lines     <= '0;
            frame_cnt <= '0;
            state     <= NO_SIGNAL;
            locked    <= 1'b0;
            values    <= '0;
        end else begin
            hs        <= {hs[0], hsync};
            vs        <= {vs[0], vsync};
            h_prev    <= hs[1];
            v_prev    <= vs[1];
            line_clk  <= h_edge ? 16'd1 : line_clk + 16'(~&line_clk);
            frame_clk <= v_edge ? 24'd1 : frame_clk + 24'(~&frame_clk);
            // a line starting together with vsync is counted in the new frame
            if (v_edge)
                line_cnt <= {11'd0, h_edge};
            else if (h_edge)
                line_cnt <= line_cnt + 12'(~&line_cnt);
            state  <= state_next;
            locked <= state_next == LOCKED;
            if (timeout) begin
                clk_line  <= '0;
                clk_frame <= '0;
                lines     <= '0;
                frame_cnt <= '0;
            end else begin
                if (h_edge && state != NO_SIGNAL)
                    clk_line <= line_clk;
                if (v_edge && state != NO_SIGNAL) begin
                    lines     <= line_cnt;
                    clk_frame <= frame_clk;
                    frame_cnt <= frame_cnt + 24'd1;
                end
            end
            if (!hold)
                values <= sel_val;
        end
    end
endmodule
